eh2_posit_round_pack: RTL and testbench
=======================================

EH2_POSIT_ROUND_PACK -- requirements
Module: eh2_posit_round_pack

Interface
REQ-001 The block SHALL have parameter POSIT_LEN, default 32: posit word width.
REQ-002 The block SHALL have parameter ES, default 3: exponent field width.
REQ-003 The block SHALL have parameter REGIME_BW, default $clog2(POSIT_LEN): signed regime field width.
REQ-004 The block SHALL have parameter FRAC_W_GRS, default POSIT_LEN-ES: fraction width, i.e. FRACTION_BW = POSIT_LEN-ES-3 bits plus guard, round and sticky.
REQ-005 The block SHALL have port clk, input, 1 bit: the only clock.
REQ-006 The block SHALL have port rst_l, input, 1 bit: reset, asynchronous and active-low.
REQ-007 The block SHALL have port in_valid, input, 1 bit: the ALU result is valid.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the block accepts the input this cycle.
REQ-009 The block SHALL have port in_sgn, input, 1 bit: result sign.
REQ-010 The block SHALL have port in_reg, input, REGIME_BW bits: signed regime k.
REQ-011 The block SHALL have port in_exp, input, ES bits: exponent.
REQ-012 The block SHALL have port in_fra, input, FRAC_W_GRS bits: fraction with the hidden bit removed; the 3 LSBs are G, R, S.
REQ-013 The block SHALL have port in_is_zero, input, 1 bit: the result is zero.
REQ-014 The block SHALL have port in_oflw_or_uflw, input, 1 bit: the exponent is out of range.
REQ-015 The block SHALL have port flush, input, 1 bit: synchronous kill of all in-flight results.
REQ-016 The block SHALL have port out_valid, output, 1 bit: the packed result is valid.
REQ-017 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-018 The block SHALL have port out_posit, output, POSIT_LEN bits: the packed posit.

Function
REQ-019 The block SHALL be a 2-stage valid/ready pipeline: S1 registers the inputs and assembles the unrounded bit string; S2 registers the rounded, signed word.
REQ-020 Latency SHALL be 2 cycles from the accepting edge to out_valid with no backpressure, with a throughput of 1 result per cycle.
REQ-021 A stage SHALL load when it is empty or when its contents move on in the same cycle; in_ready SHALL equal !s1_valid | (!s2_valid | out_ready).
REQ-022 out_posit SHALL hold stable while out_valid=1 and out_ready=0, and no result SHALL be dropped or duplicated.
REQ-023 Regime encoding SHALL be: for k>=0, (k+1) ones then a zero; for k<0, (-k) zeros then a one.
REQ-024 The bit string SHALL be regime, then in_exp, then in_fra[FRAC_W_GRS-1:3], then G, R, S; the top POSIT_LEN-1 bits form the body, the next bit is the guard, and the OR of all remaining bits is the sticky.
REQ-025 Rounding SHALL be round-to-nearest-even: increment the body iff guard & (sticky | body LSB).
REQ-026 The increment SHALL be suppressed when the body is all ones, so the result saturates at maxpos.
REQ-027 A nonzero input whose body is all zero SHALL give minpos, 0...01; a posit SHALL never round to zero.
REQ-028 For in_sgn=1, out_posit SHALL be the two's complement of {0, body}; otherwise it SHALL be {0, body}.
REQ-029 in_is_zero=1 SHALL give 0x0 regardless of the other inputs and sign.
REQ-030 in_oflw_or_uflw=1 SHALL give the saturated value (Configuration): overflow when in_reg MSB=0, underflow when it is 1.
REQ-031 in_is_zero SHALL take priority over in_oflw_or_uflw.
REQ-032 flush=1 SHALL clear s1_valid and s2_valid at the next edge, and an input presented with flush SHALL be discarded.
REQ-033 out_valid SHALL be 0 in the cycle after a flush.

Reset
REQ-034 rst_l=0 SHALL asynchronously clear s1_valid, s2_valid, out_valid and out_posit to 0.
REQ-035 in_ready SHALL be 1 during and after reset.
REQ-036 Reset asserted mid-operation SHALL discard all in-flight results, and no out_valid SHALL follow the release of reset.

Configuration
REQ-037 The block SHALL support the macro EH2_POSIT_NAR_ON_OFLW_EN.
REQ-038 With EH2_POSIT_NAR_ON_OFLW_EN defined, overflow and underflow SHALL both output NaR, 1 followed by zeros.
REQ-039 Without EH2_POSIT_NAR_ON_OFLW_EN, overflow SHALL give ±maxpos (0x7FFFFFFF or its two's complement) and underflow SHALL give ±minpos (0x00000001 or 0xFFFFFFFF).

Verification
REQ-040 The bench SHALL drive k=0, exp=0, fra=0 -> 0x40000000; sgn=1 -> 0xC0000000; exp=1 -> 0x44000000; k=1 -> 0x60000000; all with out_valid exactly 2 cycles after acceptance.
REQ-041 The bench SHALL cover rounding at k=0, exp=0: frac=0 with GRS=100 -> 0x40000000 (tie, even); frac=1 with GRS=100 -> 0x40000002; frac=0 with GRS=101 -> 0x40000001.
REQ-042 The bench SHALL drive in_is_zero=1 with sgn=1 -> 0x00000000; oflw with reg MSB=0 -> 0x7FFFFFFF without the macro and 0x80000000 with it.
REQ-043 The bench SHALL stream 8 back-to-back inputs while toggling out_ready 1,0,0,1: all 8 results emerge in order, none lost, and out_posit is stable while stalled.
REQ-044 The bench SHALL assert flush with both stages full: out_valid=0 the next cycle, and the next accepted input emerges 2 cycles later.
REQ-045 The bench SHALL pulse rst_l low mid-stream: outputs clear immediately and no stale out_valid follows.

Source files
------------

// File: rtl/eh2_posit_round_pack.sv
// Posit round-and-pack: a 2-stage valid/ready pipeline that turns regime/exponent/fraction into a packed posit.
// Define EH2_POSIT_NAR_ON_OFLW_EN to make overflow and underflow produce NaR instead of saturating.
module eh2_posit_round_pack #(
    parameter int POSIT_LEN  = 32,
    parameter int ES         = 3,
    parameter int REGIME_BW  = $clog2(POSIT_LEN),
    parameter int FRAC_W_GRS = POSIT_LEN - ES
) (
    input  logic                  clk,
    input  logic                  rst_l,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_sgn,
    input  logic [REGIME_BW-1:0]  in_reg,
    input  logic [ES-1:0]         in_exp,
    input  logic [FRAC_W_GRS-1:0] in_fra,
    input  logic                  in_is_zero,
    input  logic                  in_oflw_or_uflw,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [POSIT_LEN-1:0]  out_posit
);

    localparam int BODY_W = POSIT_LEN - 1;
    localparam int PAD_W  = 2 ** (REGIME_BW - 1);
    localparam int STR_W  = 2 + ES + FRAC_W_GRS + PAD_W;

    localparam logic [POSIT_LEN-1:0] ONE    = {{(POSIT_LEN-1){1'b0}}, 1'b1};
    localparam logic [POSIT_LEN-1:0] MAXPOS = {1'b0, {BODY_W{1'b1}}};
    localparam logic [POSIT_LEN-1:0] NAR    = {1'b1, {BODY_W{1'b0}}};
    localparam logic [BODY_W-1:0]    BODY_ONE = {{(BODY_W-1){1'b0}}, 1'b1};

    logic                  s1_valid_q, s1_valid_d;
    logic                  s1_sgn_q, s1_sgn_d;
    logic [REGIME_BW-1:0]  s1_reg_q, s1_reg_d;
    logic [ES-1:0]         s1_exp_q, s1_exp_d;
    logic [FRAC_W_GRS-1:0] s1_fra_q, s1_fra_d;
    logic                  s1_zero_q, s1_zero_d;
    logic                  s1_oflw_q, s1_oflw_d;
    logic                  s2_valid_q, s2_valid_d;
    logic [POSIT_LEN-1:0]  out_posit_q, out_posit_d;

    logic                  s1_load, s2_load;
    logic [REGIME_BW-1:0]  shamt;
    logic [STR_W-1:0]      base;
    logic [STR_W-1:0]      bit_str;
    logic [BODY_W-1:0]     body, rounded;
    logic                  guard, sticky, round_up;
    logic [POSIT_LEN-1:0]  mag, packed_word;

    assign s2_load   = !s2_valid_q | out_ready;
    assign s1_load   = !s1_valid_q | s2_load;
    assign in_ready  = s1_load;
    assign out_valid = s2_valid_q;
    assign out_posit = out_posit_q;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sgn_d   = s1_sgn_q;
        s1_reg_d   = s1_reg_q;
        s1_exp_d   = s1_exp_q;
        s1_fra_d   = s1_fra_q;
        s1_zero_d  = s1_zero_q;
        s1_oflw_d  = s1_oflw_q;
        if (s1_load) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_sgn_d  = in_sgn;
                s1_reg_d  = in_reg;
                s1_exp_d  = in_exp;
                s1_fra_d  = in_fra;
                s1_zero_d = in_is_zero;
                s1_oflw_d = in_oflw_or_uflw;
            end
        end
        if (flush) begin
            s1_valid_d = 1'b0;
        end
    end

    // Regime run is made by sign-filling an arithmetic shift: "10" seeds k>=0, "01" seeds k<0.
    always_comb begin
        shamt    = s1_reg_q[REGIME_BW-1] ? ~s1_reg_q : s1_reg_q;
        base     = {(s1_reg_q[REGIME_BW-1] ? 2'b01 : 2'b10), s1_exp_q, s1_fra_q, {PAD_W{1'b0}}};
        bit_str  = $unsigned($signed(base) >>> shamt);
        body     = bit_str[STR_W-1 -: BODY_W];
        guard    = bit_str[STR_W-1-BODY_W];
        sticky   = |bit_str[STR_W-2-BODY_W:0];
        round_up = guard & (sticky | body[0]) & ~(&body);
        rounded  = body + (round_up ? BODY_ONE : '0);
        if (rounded == '0) begin
            rounded = BODY_ONE;
        end
        mag = {1'b0, rounded};
        if (s1_zero_q) begin
            packed_word = '0;
        end else if (s1_oflw_q) begin
`ifdef EH2_POSIT_NAR_ON_OFLW_EN
            packed_word = NAR;
`else
            mag         = s1_reg_q[REGIME_BW-1] ? ONE : MAXPOS;
            packed_word = s1_sgn_q ? (~mag + ONE) : mag;
`endif
        end else begin
            packed_word = s1_sgn_q ? (~mag + ONE) : mag;
        end
    end

    always_comb begin
        s2_valid_d  = s2_valid_q;
        out_posit_d = out_posit_q;
        if (s2_load) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_posit_d = packed_word;
            end
        end
        if (flush) begin
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            s1_valid_q  <= 1'b0;
            s1_sgn_q    <= 1'b0;
            s1_reg_q    <= '0;
            s1_exp_q    <= '0;
            s1_fra_q    <= '0;
            s1_zero_q   <= 1'b0;
            s1_oflw_q   <= 1'b0;
            s2_valid_q  <= 1'b0;
            out_posit_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sgn_q    <= s1_sgn_d;
            s1_reg_q    <= s1_reg_d;
            s1_exp_q    <= s1_exp_d;
            s1_fra_q    <= s1_fra_d;
            s1_zero_q   <= s1_zero_d;
            s1_oflw_q   <= s1_oflw_d;
            s2_valid_q  <= s2_valid_d;
            out_posit_q <= out_posit_d;
        end
    end

endmodule

// File: tb/tb_eh2_posit_round_pack.sv
// Directed self-checking bench for eh2_posit_round_pack (default 32-bit, ES=3 configuration).
// Expected values track EH2_POSIT_NAR_ON_OFLW_EN when the macro is defined for the build.
module tb_eh2_posit_round_pack;

    logic        clk = 1'b0;
    logic        rst_l;
    logic        in_valid;
    logic        in_ready;
    logic        in_sgn;
    logic [4:0]  in_reg;
    logic [2:0]  in_exp;
    logic [28:0] in_fra;
    logic        in_is_zero;
    logic        in_oflw_or_uflw;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_posit;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    eh2_posit_round_pack dut (
        .clk             (clk),
        .rst_l           (rst_l),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_sgn          (in_sgn),
        .in_reg          (in_reg),
        .in_exp          (in_exp),
        .in_fra          (in_fra),
        .in_is_zero      (in_is_zero),
        .in_oflw_or_uflw (in_oflw_or_uflw),
        .flush           (flush),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_posit       (out_posit)
    );

`ifdef EH2_POSIT_NAR_ON_OFLW_EN
    localparam logic [31:0] EXP_OFLW_POS = 32'h8000_0000;
    localparam logic [31:0] EXP_OFLW_NEG = 32'h8000_0000;
    localparam logic [31:0] EXP_UFLW_POS = 32'h8000_0000;
    localparam logic [31:0] EXP_UFLW_NEG = 32'h8000_0000;
`else
    localparam logic [31:0] EXP_OFLW_POS = 32'h7FFF_FFFF;
    localparam logic [31:0] EXP_OFLW_NEG = 32'h8000_0001;
    localparam logic [31:0] EXP_UFLW_POS = 32'h0000_0001;
    localparam logic [31:0] EXP_UFLW_NEG = 32'hFFFF_FFFF;
`endif

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic driveInputs(input logic sgn, input logic [4:0] k, input logic [2:0] e,
                               input logic [28:0] f, input logic z, input logic o);
        in_sgn          = sgn;
        in_reg          = k;
        in_exp          = e;
        in_fra          = f;
        in_is_zero      = z;
        in_oflw_or_uflw = o;
    endtask

    // One isolated transaction: accepted at the first edge, visible after the second.
    task automatic applyStimulus(input string tag, input logic sgn, input logic [4:0] k,
                                 input logic [2:0] e, input logic [28:0] f, input logic z,
                                 input logic o, input logic [31:0] expected);
        @(negedge clk);
        driveInputs(sgn, k, e, f, z, o);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        #1;
        checkOutput({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput({tag, "_early_valid"}, {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        checkOutput({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
        checkOutput(tag, out_posit, expected);
    endtask

    function automatic logic [31:0] streamExpected(input int i);
        return 32'h4000_0000 | (32'(i) << 26);
    endfunction

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int sent;
        int rcvd;
        int cyc;
        logic stalled;
        logic [3:0] ready_pat;

        rst_l     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        flush     = 1'b0;
        driveInputs(1'b0, 5'd0, 3'd0, 29'd0, 1'b0, 1'b0);
        #1;
        checkOutput("reset_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("reset_out_posit", out_posit, 32'd0);
        checkOutput("reset_in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_l = 1'b1;

        applyStimulus("k0",         1'b0, 5'd0,  3'd0, 29'd0, 1'b0, 1'b0, 32'h4000_0000);
        applyStimulus("k0_neg",     1'b1, 5'd0,  3'd0, 29'd0, 1'b0, 1'b0, 32'hC000_0000);
        applyStimulus("exp1",       1'b0, 5'd0,  3'd1, 29'd0, 1'b0, 1'b0, 32'h4400_0000);
        applyStimulus("k1",         1'b0, 5'd1,  3'd0, 29'd0, 1'b0, 1'b0, 32'h6000_0000);
        applyStimulus("km1",        1'b0, 5'h1F, 3'd0, 29'd0, 1'b0, 1'b0, 32'h2000_0000);
        applyStimulus("km2",        1'b0, 5'h1E, 3'd0, 29'd0, 1'b0, 1'b0, 32'h1000_0000);
        applyStimulus("k15",        1'b0, 5'd15, 3'd0, 29'd0, 1'b0, 1'b0, 32'h7FFF_8000);
        applyStimulus("km16",       1'b0, 5'h10, 3'd0, 29'd0, 1'b0, 1'b0, 32'h0000_4000);
        applyStimulus("rnd_tie_ev", 1'b0, 5'd0,  3'd0, 29'd4,  1'b0, 1'b0, 32'h4000_0000);
        applyStimulus("rnd_tie_od", 1'b0, 5'd0,  3'd0, 29'd12, 1'b0, 1'b0, 32'h4000_0002);
        applyStimulus("rnd_sticky", 1'b0, 5'd0,  3'd0, 29'd5,  1'b0, 1'b0, 32'h4000_0001);
        applyStimulus("rnd_carry",  1'b0, 5'd0,  3'd7, 29'h1FFF_FFFF, 1'b0, 1'b0, 32'h6000_0000);
        applyStimulus("rnd_carry_n",1'b1, 5'd0,  3'd7, 29'h1FFF_FFFF, 1'b0, 1'b0, 32'hA000_0000);
        applyStimulus("zero_neg",   1'b1, 5'd3,  3'd5, 29'd77, 1'b1, 1'b0, 32'h0000_0000);
        applyStimulus("zero_prio",  1'b1, 5'd0,  3'd0, 29'd0, 1'b1, 1'b1, 32'h0000_0000);
        applyStimulus("oflw_pos",   1'b0, 5'd2,  3'd0, 29'd0, 1'b0, 1'b1, EXP_OFLW_POS);
        applyStimulus("oflw_neg",   1'b1, 5'd2,  3'd0, 29'd0, 1'b0, 1'b1, EXP_OFLW_NEG);
        applyStimulus("uflw_pos",   1'b0, 5'h1C, 3'd0, 29'd0, 1'b0, 1'b1, EXP_UFLW_POS);
        applyStimulus("uflw_neg",   1'b1, 5'h1C, 3'd0, 29'd0, 1'b0, 1'b1, EXP_UFLW_NEG);

        // Streaming with out_ready cycling 1,0,0,1; a stalled output must hold the head of the queue.
        ready_pat = 4'b1001;
        sent      = 0;
        rcvd      = 0;
        stalled   = 1'b0;
        for (cyc = 0; cyc < 100 && rcvd < 8; cyc++) begin
            @(negedge clk);
            if (stalled) begin
                checkOutput("stream_stall_valid", {31'b0, out_valid}, 32'd1);
            end
            if (out_valid) begin
                checkOutput("stream_data", out_posit, streamExpected(rcvd));
            end
            out_ready = ready_pat[cyc % 4];
            in_valid  = (sent < 8);
            driveInputs(1'b0, 5'd0, 3'(sent), 29'd0, 1'b0, 1'b0);
            #1;
            stalled = out_valid & !out_ready;
            if (out_valid && out_ready) rcvd++;
            if (in_valid && in_ready) sent++;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checkOutput("stream_count", 32'(rcvd), 32'd8);

        // Flush with both stages full; the input offered alongside the flush must vanish.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        driveInputs(1'b0, 5'd1, 3'd0, 29'd0, 1'b0, 1'b0);
        @(negedge clk);
        driveInputs(1'b0, 5'd2, 3'd0, 29'd0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("flush_full_valid", {31'b0, out_valid}, 32'd1);
        driveInputs(1'b0, 5'd3, 3'd0, 29'd0, 1'b0, 1'b0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checkOutput("flush_valid", {31'b0, out_valid}, 32'd0);
        out_ready = 1'b1;
        driveInputs(1'b0, 5'd0, 3'd2, 29'd0, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("post_flush_early", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        checkOutput("post_flush_valid", {31'b0, out_valid}, 32'd1);
        checkOutput("post_flush_data", out_posit, 32'h4800_0000);
        @(negedge clk);
        checkOutput("post_flush_drain", {31'b0, out_valid}, 32'd0);

        // Reset asserted with results in flight.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        driveInputs(1'b0, 5'd1, 3'd0, 29'd0, 1'b0, 1'b0);
        @(negedge clk);
        driveInputs(1'b1, 5'd1, 3'd0, 29'd0, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("pre_rst_valid", {31'b0, out_valid}, 32'd1);
        rst_l = 1'b0;
        #1;
        checkOutput("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("mid_rst_posit", out_posit, 32'd0);
        checkOutput("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        rst_l     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("post_rst_valid", {31'b0, out_valid}, 32'd0);
        end
        checkOutput("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
